display_scan: RTL and testbench

Multiplexed seven-segment display driver that consumes the packed BCD/hex digit vector and key-strobe produced by the keypad input path and drives a common-anode/cathode multi-digit display. Operates as a time-multiplexing digit scanner with an anti-ghosting guard interval between digits. Buffers new values and commits them only at frame boundaries, so a displayed frame never mixes two values. Sits between the keypad/shift-register path and the board display pins.

---
 rtl/display_pkg.sv | 28 ++
 rtl/hex_to_seg.sv | 32 +++
 rtl/display_scan.sv | 135 +++++++++++++
 tb/tb_display_scan.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and segment patterns for the multiplexed seven-segment scanner.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to seven-segment decoder, full hex with A/b/C/d/E/F glyphs.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed digit scanner with a dark guard interval before every slot.
// New values are buffered and committed only when a frame starts over at digit 0.
module display_scan
  import display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DWELL      = 50000,
  parameter int GUARD      = 500,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*4-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0]     GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL - 1);
  localparam logic [DIGITS-1:0] AN_IDLE    = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_IDLE   = {7{ACTIVE_LOW}};

  state_t                state_reg, state_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [DIGITS*4-1:0]   hold_reg, hold_next;
  logic [DIGITS*4-1:0]   snap_reg, snap_next;
  logic                  pending_reg, pending_next;
  logic                  commit;

  logic [DIGITS-1:0]     an_reg, an_act;
  logic [6:0]            seg_reg, seg_act, seg_raw;
  logic                  dp_reg, dp_act;

  logic [3:0]            nib [DIGITS];
  logic [DIGITS-1:0]     blank_vec;
  logic                  blank;

  // blank_vec[i]: nibble i and every nibble above it are zero; digit 0 is never a candidate.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nib[gi] = snap_reg[4*gi +: 4];
    if (gi == 0) begin : g_first
      assign blank_vec[gi] = 1'b0;
    end else begin : g_upper
      assign blank_vec[gi] = (snap_reg[DIGITS*4-1:4*gi] == '0);
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg + 1'b1;
    commit     = 1'b0;
    case (state_reg)
      ST_GUARD: begin
        if (cnt_reg == GUARD_LAST) begin
          state_next = ST_SHOW;
          cnt_next   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_reg == DWELL_LAST) begin
          state_next = ST_GUARD;
          cnt_next   = '0;
          idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
          commit     = (idx_reg == IDX_LAST);
        end
      end
    endcase
  end

  // A load coinciding with a commit still lands in hold and keeps pending set.
  assign hold_next    = load ? value : hold_reg;
  assign pending_next = load | (pending_reg & ~commit);
  assign snap_next    = (commit && pending_reg) ? hold_reg : snap_reg;

  hex_to_seg u_dec (
    .nib (nib[idx_next]),
    .seg (seg_raw)
  );

  assign blank = blank_lz & blank_vec[idx_next];

  // Output drive is computed from the next state so pins move on the same edge as the FSM.
  always_comb begin
    an_act  = '0;
    seg_act = SEG_OFF;
    dp_act  = 1'b0;
    if (state_next == ST_SHOW) begin
      an_act[idx_next] = 1'b1;
      if (!blank) begin
        seg_act = seg_raw;
        dp_act  = dp_mask[idx_next];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_GUARD;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      hold_reg    <= '0;
      snap_reg    <= '0;
      pending_reg <= 1'b0;
      an_reg      <= AN_IDLE;
      seg_reg     <= SEG_IDLE;
      dp_reg      <= ACTIVE_LOW;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      hold_reg    <= hold_next;
      snap_reg    <= snap_next;
      pending_reg <= pending_next;
      an_reg      <= an_act ^ AN_IDLE;
      seg_reg     <= seg_act ^ SEG_IDLE;
      dp_reg      <= dp_act ^ ACTIVE_LOW;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: stimulus queues expected slots, a monitor
// pops one per lit slot and checks start edge, digit enable, segments and dp.
module tb_display_scan;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int GUARD  = 1;

  // Active-low glyphs, hand-derived.
  localparam logic [6:0] S0   = 7'h40;
  localparam logic [6:0] S1   = 7'h79;
  localparam logic [6:0] S2   = 7'h24;
  localparam logic [6:0] S5   = 7'h12;
  localparam logic [6:0] S8   = 7'h00;
  localparam logic [6:0] S9   = 7'h10;
  localparam logic [6:0] SA   = 7'h08;
  localparam logic [6:0] SC   = 7'h46;
  localparam logic [6:0] SD   = 7'h21;
  localparam logic [6:0] SF   = 7'h0E;
  localparam logic [6:0] SBLK = 7'h7F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  display_scan #(
    .DIGITS     (DIGITS),
    .DWELL      (DWELL),
    .GUARD      (GUARD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         edge_no;
  } slot_t;

  slot_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc;

  // Edge number since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_slot(input int f, input int d, input logic [6:0] s, input logic dpv);
    slot_t it;
    it.an      = ~(4'b0001 << d);
    it.seg     = s;
    it.dp      = dpv;
    it.edge_no = 20 * f + 5 * d + 1;
    exp_q.push_back(it);
  endtask

  task automatic push_frame(input int f, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpv);
    push_slot(f, 0, s0, dpv[0]);
    push_slot(f, 1, s1, dpv[1]);
    push_slot(f, 2, s2, dpv[2]);
    push_slot(f, 3, s3, dpv[3]);
  endtask

  // Return at the falling edge just before edge e, so drives are sampled at edge e.
  task automatic wait_cyc(input int e);
    while (cyc < e - 1) @(negedge clk);
    chk("sched", cyc, e - 1);
  endtask

  task automatic do_load(input int e, input logic [15:0] v);
    wait_cyc(e);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Monitor
  initial begin
    logic [3:0] prev_an;
    int         lit_len;
    bit         have_cur;
    slot_t      cur;
    prev_an  = 4'hF;
    lit_len  = 0;
    have_cur = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_an  = 4'hF;
        lit_len  = 0;
        have_cur = 0;
      end else if (an != 4'hF) begin
        if (prev_an == 4'hF) begin
          $display("[TB] slot edge=%0d an=%h seg=%h dp=%b", cyc, an, seg, dp);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            have_cur = 0;
            $display("FAIL unexpected_slot: got an=%h expected no slot (edge %0d)", an, cyc);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1;
            chk("slot_start", cyc, cur.edge_no);
            chk("slot_an", an, cur.an);
            chk("slot_seg", seg, cur.seg);
            chk("slot_dp", dp, cur.dp);
          end
          lit_len = 1;
        end else begin
          lit_len++;
          if (have_cur) begin
            chk("hold_an", an, cur.an);
            chk("hold_seg", seg, cur.seg);
            chk("hold_dp", dp, cur.dp);
          end
        end
      end else begin
        if (prev_an != 4'hF) chk("dwell_len", lit_len, DWELL);
        chk("dark_seg", seg, SBLK);
        chk("dark_dp", dp, 1'b1);
      end
      prev_an = an;
    end
  end

  // Stimulus
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, SBLK);
    chk("rst_dp", dp, 1'b1);

    push_frame(0, S0, S0, S0, S0, 4'b1111);
    reset = 1'b0;
    #1;
    chk("guard_after_rst", an, 4'hF);

    do_load(10, 16'h12AF);
    push_frame(1, SF, SA, S2, S1, 4'b1111);

    do_load(25, 16'h1111);
    do_load(27, 16'h2222);
    push_frame(2, S2, S2, S2, S2, 4'b1111);

    // 89CD pending, then 0050 loaded on the commit edge itself.
    do_load(50, 16'h89CD);
    do_load(60, 16'h0050);
    push_frame(3, SD, SC, S9, S8, 4'b1111);
    push_frame(4, S0, S5, SBLK, SBLK, 4'b1111);

    wait_cyc(62);
    blank_lz = 1'b1;

    do_load(85, 16'h0000);
    push_frame(5, S0, SBLK, SBLK, SBLK, 4'b1111);

    wait_cyc(120);
    blank_lz = 1'b0;
    dp_mask  = 4'b0100;
    push_slot(6, 0, S0, 1'b1);
    push_slot(6, 1, S0, 1'b1);
    push_slot(6, 2, S0, 1'b0);

    // Pending 7777 must be lost by the reset during the digit 2 slot.
    do_load(125, 16'h7777);
    wait_cyc(133);
    reset = 1'b1;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_seg", seg, SBLK);
    chk("async_rst_dp", dp, 1'b1);
    chk("rst_queue_empty", exp_q.size(), 0);

    push_frame(0, S0, S0, S0, S0, 4'b1011);
    push_slot(1, 0, S0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("restart_guard", an, 4'hF);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d slots outstanding expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
